// File: rtl/nibble_addsub_seq_pkg.sv
// Shared widths and the FSM state encoding for the nibble-serial add/sub unit.
package nibble_addsub_seq_pkg;

    localparam int OP_W   = 16;
    localparam int NIB_W  = 4;
    localparam int STEPS  = OP_W / NIB_W;
    localparam int STEP_W = $clog2(STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_addsub_seq_core.sv
// One-nibble adder/subtractor. b is inverted by mode internally; the carry-in
// comes from the caller so it can chain nibbles across cycles.
module addsub4_core
    import nibble_addsub_seq_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             mode,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             co
);

    logic [NIB_W-1:0] beff;

    // Conditional invert of b, then a plain ripple add with carry-in.
    always_comb begin
        beff    = b ^ {NIB_W{mode}};
        {co, s} = {1'b0, a} + {1'b0, beff} + {{NIB_W{1'b0}}, cin};
    end

endmodule

// File: rtl/nibble_addsub_seq.sv
// 16-bit add/sub computed one nibble per cycle through a single 4-bit core.
// Accept in IDLE, four RUN cycles LSB nibble first, hold the result in DONE
// until the consumer takes it.
module nibble_addsub_seq
    import nibble_addsub_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    input  logic            mode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] result,
    output logic            cout,
    output logic            ovf,
    output logic            zero
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    state_t            state, state_nxt;
    logic [STEP_W-1:0] step;
    logic              carry;
    logic [OP_W-1:0]   a_q, b_q;
    logic              mode_q;

    logic [NIB_W-1:0]  nib_a, nib_b, nib_s;
    logic              nib_co;
    logic [OP_W-1:0]   res_nxt;
    logic              ovf_nxt;
    logic              last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last      = (step == LAST_STEP);

    // Select the operand nibbles for this step and splice the core output
    // into the running result; ovf uses the fully spliced result.
    always_comb begin
        nib_a   = a_q[step*NIB_W +: NIB_W];
        nib_b   = b_q[step*NIB_W +: NIB_W];
        res_nxt = result;
        res_nxt[step*NIB_W +: NIB_W] = nib_s;
        ovf_nxt = (a_q[OP_W-1] == (b_q[OP_W-1] ^ mode_q)) &&
                  (res_nxt[OP_W-1] != a_q[OP_W-1]);
    end

    addsub4_core u_core (
        .a    (nib_a),
        .b    (nib_b),
        .mode (mode_q),
        .cin  (carry),
        .s    (nib_s),
        .co   (nib_co)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a result handshake always returns to IDLE first,
    // which leaves one bubble between back-to-back jobs.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Operand capture, nibble sequencing and final flag registration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            step   <= '0;
            carry  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q    <= a;
                    b_q    <= b;
                    mode_q <= mode;
                    step   <= '0;
                    carry  <= mode;
                end
                RUN: begin
                    result <= res_nxt;
                    carry  <= nib_co;
                    step   <= step + 1'b1;
                    if (last) begin
                        cout <= nib_co;
                        ovf  <= ovf_nxt;
                        zero <= (res_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_addsub_seq.sv
// Bench for nibble_addsub_seq: table of vectors plus hand sequences for
// backpressure, input-held-high and mid-job reset, checked via a scoreboard.
module tb_nibble_addsub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, mode, out_valid, out_ready;
    logic [15:0] a, b, result;
    logic        cout, ovf, zero;

    typedef struct {
        logic [15:0] a, b;
        logic        m;
        logic [15:0] r;
        logic        c, v, z;
    } vec_t;

    vec_t tbl[14];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    nibble_addsub_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .ovf(ovf), .zero(zero)
    );

    function automatic vec_t model(logic [15:0] x, logic [15:0] y, logic m);
        vec_t        e;
        logic [15:0] be;
        logic [16:0] s;
        be  = y ^ {16{m}};
        s   = {1'b0, x} + {1'b0, be} + {16'd0, m};
        e.a = x; e.b = y; e.m = m;
        e.r = s[15:0];
        e.c = s[16];
        e.v = (x[15] == be[15]) && (s[15] != x[15]);
        e.z = (s[15:0] == 16'd0);
        return e;
    endfunction

    function automatic vec_t mk(logic [15:0] x, logic [15:0] y, logic m,
                                logic [15:0] r, logic c, logic v, logic z);
        vec_t e;
        e.a = x; e.b = y; e.m = m; e.r = r; e.c = c; e.v = v; e.z = z;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Drive one operand, wait (bounded) for acceptance, push the expectation.
    task automatic start_job(input vec_t e);
        int n;
        @(negedge clk);
        a = e.a; b = e.b; mode = e.m; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        chk("accept_ready", {31'd0, in_ready}, 32'd1);
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom);
    endtask

    // Called #1 after the accepting edge: check latency, optional hold, result.
    task automatic finish_job(input int hold);
        int          lat;
        vec_t        e;
        logic [18:0] snap;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("latency", lat, 4);
        snap = {result, cout, ovf, zero};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_stable", {13'd0, result, cout, ovf, zero}, {13'd0, snap});
            chk("hold_in_ready", {30'd0, in_ready, out_valid}, 32'd1);
        end
        e = sb.pop_front();
        chk("result", {16'd0, result}, {16'd0, e.r});
        chk("flags",  {29'd0, cout, ovf, zero}, {29'd0, e.c, e.v, e.z});
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        chk("back_idle", {30'd0, in_ready, out_valid}, 32'd2);
        chk("idle_retain", {16'd0, result}, {16'd0, e.r});
    endtask

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; mode = 1'b0;
        tbl[0] = mk(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
        tbl[1] = mk(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        tbl[2] = mk(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        tbl[3] = mk(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        tbl[4] = mk(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        tbl[5] = mk(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        tbl[6] = mk(16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        tbl[7] = mk(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        for (int i = 8; i < 14; i++)
            tbl[i] = model(16'($urandom), 16'($urandom), 1'($urandom));

        #12;
        chk("rst_outputs", {13'd0, result, cout, ovf, zero}, 32'd0);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst_handshake", {30'd0, in_ready, out_valid}, 32'd2);

        for (int i = 0; i < 14; i++) begin
            start_job(tbl[i]);
            finish_job(0);
        end

        // Backpressure for 10 cycles with the next operand held valid the
        // whole time: it must be taken once, right after the handshake.
        start_job(model(16'hABCD, 16'h1111, 1'b0));
        a = 16'h0F0F; b = 16'h00F1; mode = 1'b1; in_valid = 1'b1;
        finish_job(10);
        @(posedge clk); #1;
        chk("second_accept", {31'd0, in_ready}, 32'd0);
        sb.push_back(model(16'h0F0F, 16'h00F1, 1'b1));
        in_valid = 1'b0;
        finish_job(0);
        @(posedge clk); #1;
        chk("no_reaccept", {30'd0, in_ready, out_valid}, 32'd2);

        // Reset in the second RUN cycle aborts the job.
        start_job(model(16'h4321, 16'h1234, 1'b0));
        @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("abort_outputs", {12'd0, result, cout, ovf, zero, out_valid}, 32'd0);
        void'(sb.pop_front());
        @(negedge clk); rst = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin @(posedge clk); #1; if (out_valid) n++; end
        chk("abort_no_valid", n, 0);
        start_job(model(16'h4321, 16'h1234, 1'b1));
        finish_job(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
